// File: rtl/num_hex.sv
// num_hex: single-digit seven-segment driver for codes 0..3.
// Supports blanking and periodic flashing. The output is decoded purely
// from registered state, so there is no input-to-output combinational path.
// Reset asserts asynchronously and releases through a two-flop synchronizer.
module num_hex #(
  parameter int unsigned FLASH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] in,
  input  logic       blank,
  input  logic       flash,
  output logic [6:0] out
);

  // Terminal count of the flash half-period counter.
  localparam logic [7:0] CntMax = 8'(FLASH_CYCLES - 1);

  // Active-low segment patterns (bit0 = a ... bit6 = g).
  localparam logic [6:0] SegOff   = 7'b1111111;
  localparam logic [6:0] SegZero  = 7'b1000000;
  localparam logic [6:0] SegOne   = 7'b1111001;
  localparam logic [6:0] SegTwo   = 7'b0100100;
  localparam logic [6:0] SegThree = 7'b0110000;

  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  logic [1:0] code_q,  code_d;
  logic       blank_q, blank_d;
  logic       flash_q, flash_d;
  logic [7:0] cnt_q,   cnt_d;
  logic       phase_q, phase_d;

  // Reset synchronizer: assertion is immediate, release is aligned to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Next-state logic for the captured code, mode flags and flash timer.
  always_comb begin
    code_d  = code_q;
    blank_d = blank;
    flash_d = flash;
    cnt_d   = cnt_q;
    phase_d = phase_q;

    if (enable) begin
      code_d = in;
    end

    if (flash) begin
      if (cnt_q == CntMax) begin
        cnt_d   = 8'd0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + 8'd1;
        phase_d = phase_q;
      end
    end else begin
      cnt_d   = 8'd0;
      phase_d = 1'b1;
    end
  end

  // State registers; the internal reset forces the visible-zero state.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      code_q  <= 2'd0;
      blank_q <= 1'b0;
      flash_q <= 1'b0;
      cnt_q   <= 8'd0;
      phase_q <= 1'b1;
    end else begin
      code_q  <= code_d;
      blank_q <= blank_d;
      flash_q <= flash_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Output decode: blank wins, then the flash off-phase, then the digit.
  always_comb begin
    out = SegOff;
    if (blank_q) begin
      out = SegOff;
    end else if (flash_q && !phase_q) begin
      out = SegOff;
    end else begin
      case (code_q)
        2'd0:    out = SegZero;
        2'd1:    out = SegOne;
        2'd2:    out = SegTwo;
        default: out = SegThree;
      endcase
    end
  end

endmodule

// File: tb/tb_num_hex.sv
// Directed scoreboard bench for num_hex: each step pushes its expected
// segment pattern and the value is popped and compared once the DUT has
// had the chance to produce it.
module tb_num_hex;

  localparam logic [6:0] Off   = 7'b1111111;
  localparam logic [6:0] Zero  = 7'b1000000;
  localparam logic [6:0] One   = 7'b1111001;
  localparam logic [6:0] Two   = 7'b0100100;
  localparam logic [6:0] Three = 7'b0110000;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] inData;
  logic       blank;
  logic       flash;
  logic [6:0] out;

  int checks;
  int failures;

  logic [6:0] expQ[$];
  string      tagQ[$];

  num_hex #(.FLASH_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .in(inData),
    .blank(blank),
    .flash(flash),
    .out(out)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pops the oldest expectation and compares it with the DUT output.
  task automatic checkOutput();
    logic [6:0] e;
    string      t;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $error("[TB] FAIL scoreboard_empty: observed=%b expected=queued_value", out);
    end else begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      assert (out === e) else begin
        failures++;
        $error("[TB] FAIL %s: observed=%b expected=%b", t, out, e);
      end
    end
  endtask

  // Queues an expectation for the current, edge-free moment and checks it.
  task automatic checkNow(input logic [6:0] e, input string t);
    expQ.push_back(e);
    tagQ.push_back(t);
    checkOutput();
  endtask

  // Drives one cycle of inputs, queues the expected result, clocks, checks.
  task automatic applyStimulus(input logic en, input logic [1:0] d,
                               input logic bl, input logic fl,
                               input logic [6:0] e, input string t);
    enable = en;
    inData = d;
    blank  = bl;
    flash  = fl;
    expQ.push_back(e);
    tagQ.push_back(t);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    enable   = 1'b0;
    inData   = 2'd0;
    blank    = 1'b0;
    flash    = 1'b0;

    // Reset state and inputs ignored during reset.
    #2;
    checkNow(Zero, "reset_state");
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b1, Zero, "reset_hold");
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b1, Zero, "reset_hold");

    // Release, then let the synchronizer settle with idle inputs.
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, Zero, "sync_idle");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, Zero, "sync_idle");

    // Enable low must not capture; then load 2, 1, 0 with one-cycle latency.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 2'd3, 1'b0, 1'b0, Zero, "enable_low");
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, Two,  "load2");
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, One,  "load1");
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, Zero, "load0");

    // Load 3 then hold it while in toggles.
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, Three, "load3");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, Three, "hold3");
    applyStimulus(1'b0, 2'd1, 1'b0, 1'b0, Three, "hold3");
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b0, Three, "hold3");

    // Mid-cycle asynchronous reset with code 3 showing.
    #3;
    reset = 1'b0;
    #1;
    checkNow(Zero, "async_reset");
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b1, Zero, "reset_hold2");
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b1, Zero, "reset_hold2");
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, Zero, "sync_idle2");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, Zero, "sync_idle2");

    // Blank with simultaneous load, then unblank reveals the new digit.
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, One, "load1b");
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, Off, "blank_load");
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, Off, "blank_load");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, Two, "unblank");

    // Flash with 4-cycle half-periods: visible while (k/4) is even.
    for (int k = 1; k <= 12; k++)
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1,
                    (((k / 4) % 2) == 0) ? Two : Off, "flash_phase");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, Two, "flash_off");

    // Reset pulse during the flash off-phase.
    for (int k = 1; k <= 5; k++)
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1,
                    (((k / 4) % 2) == 0) ? Two : Off, "flash_phase2");
    #3;
    reset = 1'b0;
    #1;
    checkNow(Zero, "flash_reset");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, Zero, "flash_reset_hold");
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, Zero, "sync_idle3");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, Zero, "sync_idle3");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, Zero, "post_reset_steady");

    checks++;
    assert (expQ.size() == 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_drain: observed=%0d expected=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
